fm_scan_ctrl: RTL

- Channel-scan controller for the receive chain.
- Drives the NCO frequency word (LO_fre) of the IQ demodulator and steps it across a programmed channel raster.
- Measures I/Q signal power on each channel and locks onto the first channel at or above threshold. Resumes scanning when that carrier drops.
- Sits between the configuration/control logic and the IQ/FM demodulator pair; consumes the demodulator's baseband I/Q.

---
 rtl/fm_scan_ctrl_if.sv | 39 +++
 rtl/fm_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fm_scan_ctrl_if.sv
// Control, configuration, sample and status bundle of the channel-scan controller.
// The slave modport is the controller; the master modport is the config/demod side.
interface fm_scan_ctrl_if #(
    parameter int FREQ_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 12,
    parameter int CH_WIDTH     = 8,
    parameter int DWELL_LOG2   = 8
);
    localparam int POW_W = SAMPLE_WIDTH + 1 + DWELL_LOG2;

    logic                           scan_start;
    logic                           scan_stop;
    logic        [FREQ_WIDTH-1:0]   base_fre;
    logic        [FREQ_WIDTH-1:0]   step_fre;
    logic        [CH_WIDTH-1:0]     ch_count;
    logic        [POW_W-1:0]        threshold;
    logic                           sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] I_IN;
    logic signed [SAMPLE_WIDTH-1:0] Q_IN;
    logic        [FREQ_WIDTH-1:0]   LO_fre;
    logic        [CH_WIDTH-1:0]     ch_idx;
    logic                           scan_busy;
    logic                           locked;
    logic        [POW_W-1:0]        power_out;
    logic                           power_valid;
    logic                           scan_wrap;

    modport master (
        output scan_start, scan_stop, base_fre, step_fre, ch_count, threshold,
               sample_valid, I_IN, Q_IN,
        input  LO_fre, ch_idx, scan_busy, locked, power_out, power_valid, scan_wrap
    );

    modport slave (
        input  scan_start, scan_stop, base_fre, step_fre, ch_count, threshold,
               sample_valid, I_IN, Q_IN,
        output LO_fre, ch_idx, scan_busy, locked, power_out, power_valid, scan_wrap
    );
endinterface

// File: rtl/fm_scan_ctrl.sv
// Channel-scan controller: steps the NCO word over a raster, measures |I|+|Q| power, locks/releases.
// Define FM_SCAN_HYST_EN to release lock against threshold - threshold/4 instead of threshold.
module fm_scan_ctrl #(
    parameter int FREQ_WIDTH    = 32,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int CH_WIDTH      = 8,
    parameter int SETTLE_CYCLES = 256,
    parameter int DWELL_LOG2    = 8,
    parameter int HOLD_MISS     = 3
) (
    input  logic           clk_in,
    input  logic           RST,
    fm_scan_ctrl_if.slave  bus
);
    localparam int POW_W  = SAMPLE_WIDTH + 1 + DWELL_LOG2;
    localparam int SMP_W  = DWELL_LOG2 + 1;
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int MISS_W = $clog2(HOLD_MISS + 1);

    typedef enum logic [2:0] {S_IDLE, S_TUNE, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCK} state_t;

    state_t                state_q, state_d;
    logic [FREQ_WIDTH-1:0] lo_q, lo_d, base_q, base_d, step_q, step_d;
    logic [CH_WIDTH-1:0]   idx_q, idx_d, count_q, count_d;
    logic [POW_W-1:0]      thr_q, thr_d, acc_q, acc_d, pow_q, pow_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic [SMP_W-1:0]      smp_q, smp_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic                  pv_q, pv_d, wrap_q, wrap_d;

    logic [POW_W-1:0]        acc_add;
    logic [POW_W-1:0]        thr_rel;
    logic                    last_smp, at_last, is_miss;
    logic [CH_WIDTH-1:0]     adv_idx;
    logic [FREQ_WIDTH-1:0]   adv_lo;

    // Unsigned magnitude; the most negative code maps to 2^(SAMPLE_WIDTH-1) without saturating.
    function automatic logic [SAMPLE_WIDTH-1:0] mag(input logic [SAMPLE_WIDTH-1:0] x);
        return x[SAMPLE_WIDTH-1] ? SAMPLE_WIDTH'(~x + 1'b1) : x;
    endfunction

    assign acc_add  = acc_q + POW_W'({1'b0, mag(bus.I_IN)} + {1'b0, mag(bus.Q_IN)});
    assign last_smp = bus.sample_valid && (smp_q == SMP_W'((1 << DWELL_LOG2) - 1));
    assign at_last  = (idx_q == count_q - 1'b1);
    assign adv_idx  = at_last ? '0 : idx_q + 1'b1;
    assign adv_lo   = at_last ? base_q : lo_q + step_q;

`ifdef FM_SCAN_HYST_EN
    assign thr_rel = thr_q - (thr_q >> 2);
`else
    assign thr_rel = thr_q;
`endif
    assign is_miss = (acc_add < thr_rel);

    // NOTE: every next-state value takes its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        base_d   = base_q;
        step_d   = step_q;
        idx_d    = idx_q;
        count_d  = count_q;
        thr_d    = thr_q;
        acc_d    = acc_q;
        pow_d    = pow_q;
        settle_d = settle_q;
        smp_d    = smp_q;
        miss_d   = miss_q;
        pv_d     = 1'b0;
        wrap_d   = 1'b0;

        if (bus.scan_stop) begin
            state_d = S_IDLE;
            acc_d   = '0;
            smp_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.scan_start && bus.ch_count != '0) begin
                        base_d  = bus.base_fre;
                        step_d  = bus.step_fre;
                        count_d = bus.ch_count;
                        thr_d   = bus.threshold;
                        lo_d    = bus.base_fre;
                        idx_d   = '0;
                        state_d = S_TUNE;
                    end
                end
                S_TUNE: begin
                    settle_d = '0;
                    acc_d    = '0;
                    smp_d    = '0;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_MEASURE;
                    else                                       settle_d = settle_q + 1'b1;
                end
                S_MEASURE: begin
                    if (bus.sample_valid) begin
                        acc_d = acc_add;
                        smp_d = smp_q + 1'b1;
                    end
                    if (last_smp) begin
                        pow_d   = acc_add;
                        pv_d    = 1'b1;
                        state_d = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (acc_q >= thr_q) begin
                        miss_d  = '0;
                        acc_d   = '0;
                        smp_d   = '0;
                        state_d = S_LOCK;
                    end else begin
                        lo_d    = adv_lo;
                        idx_d   = adv_idx;
                        wrap_d  = at_last;
                        state_d = S_TUNE;
                    end
                end
                S_LOCK: begin
                    if (bus.sample_valid) begin
                        acc_d = acc_add;
                        smp_d = smp_q + 1'b1;
                    end
                    if (last_smp) begin
                        pow_d = acc_add;
                        pv_d  = 1'b1;
                        acc_d = '0;
                        smp_d = '0;
                        if (!is_miss) begin
                            miss_d = '0;
                        end else if (miss_q == MISS_W'(HOLD_MISS - 1)) begin
                            lo_d    = adv_lo;
                            idx_d   = adv_idx;
                            wrap_d  = at_last;
                            state_d = S_TUNE;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            base_q   <= '0;
            step_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            thr_q    <= '0;
            acc_q    <= '0;
            pow_q    <= '0;
            settle_q <= '0;
            smp_q    <= '0;
            miss_q   <= '0;
            pv_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            base_q   <= base_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            thr_q    <= thr_d;
            acc_q    <= acc_d;
            pow_q    <= pow_d;
            settle_q <= settle_d;
            smp_q    <= smp_d;
            miss_q   <= miss_d;
            pv_q     <= pv_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.LO_fre      = lo_q;
    assign bus.ch_idx      = idx_q;
    assign bus.scan_busy   = (state_q != S_IDLE);
    assign bus.locked      = (state_q == S_LOCK);
    assign bus.power_out   = pow_q;
    assign bus.power_valid = pv_q;
    assign bus.scan_wrap   = wrap_q;
endmodule
